// File: rtl/stream_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_mux_pkg
//  Description : Shared types and helpers for the stream_mux_rr multiplexer.
//                Provides the mode encoding and the round-robin wrap function.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_mux_pkg;

    typedef enum logic {
        MODE_RR    = 1'b0,
        MODE_FIXED = 1'b1
    } mux_mode_e;

    // Successor of idx in a ring of n entries (n-1 wraps back to 0).
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx == n - 32'd1) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Returns the first
//                requesting index at or above ptr, wrapping N-1 -> 0.
//  Ports       : req       - per-channel requests
//                ptr       - highest-priority index for this decision
//                gnt_idx   - granted index (0 when nothing granted)
//                gnt_valid - a request was found
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_valid
);

    logic [SW-1:0] w_cand;

    // Walk the ring starting at ptr; the first hit wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        w_cand    = '0;
        for (int i = 0; i < N; i++) begin
            w_cand = SW'((int'(ptr) + i) % N);
            if (!gnt_valid && req[w_cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module      : stream_mux_rr
//  Description : N-channel, W-bit stream multiplexer with valid/ready
//                handshakes and a registered output stage. Mode 0 arbitrates
//                round-robin, mode 1 forwards the channel picked by sel.
//  Option      : STREAM_MUX_LOCK_EN - hold the grant on one channel until a
//                beat with in_last=1 closes the packet.
//  Ports       : clk, rst                  - clock, sync active-high reset
//                mode, sel                 - arbitration mode / fixed index
//                in_valid/in_data/in_last  - producer side, channel k at [k*W +: W]
//                in_ready                  - one-hot (or zero) accept
//                out_valid/out_data/out_sel/out_last - registered beat
//                out_ready                 - consumer accept
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int W  = 3,
    parameter  int N  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_last,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_sel,
    output logic           out_last,
    input  logic           out_ready
);

    logic          r_out_valid;
    logic [W-1:0]  r_out_data;
    logic [SW-1:0] r_out_sel;
    logic [SW-1:0] r_ptr;

    mux_mode_e     w_mode;
    logic          w_load;
    logic          w_rr_valid;
    logic [SW-1:0] w_rr_idx;
    logic          w_fix_valid;
    logic          w_gnt_valid;
    logic [SW-1:0] w_gnt_idx;
    logic          w_xfer;
    logic          w_adv;

    assign w_mode = mux_mode_e'(mode);

    // Register accepts a beat when empty or when its current beat drains.
    assign w_load = ~r_out_valid | out_ready;

    rr_arbiter #(.N(N)) u_arb (
        .req       (in_valid),
        .ptr       (r_ptr),
        .gnt_idx   (w_rr_idx),
        .gnt_valid (w_rr_valid)
    );

    // Out-of-range sel values never grant.
    assign w_fix_valid = (int'(sel) < N) && in_valid[sel];

`ifdef STREAM_MUX_LOCK_EN
    logic          r_lock;
    logic [SW-1:0] r_lock_idx;
    logic          r_out_last;
`endif

    always_comb begin
        if (w_mode == MODE_FIXED) begin
            w_gnt_idx   = sel;
            w_gnt_valid = w_fix_valid;
        end else begin
            w_gnt_idx   = w_rr_idx;
            w_gnt_valid = w_rr_valid;
        end
`ifdef STREAM_MUX_LOCK_EN
        // An open packet overrides both mode and pointer.
        if (r_lock) begin
            w_gnt_idx   = r_lock_idx;
            w_gnt_valid = in_valid[r_lock_idx];
        end
`endif
    end

    assign w_xfer   = w_load & w_gnt_valid & ~rst;
    assign in_ready = w_xfer ? (N'(1) << w_gnt_idx) : '0;

`ifdef STREAM_MUX_LOCK_EN
    // Pointer only moves once the packet closes, so the next packet
    // starts after the channel that just finished.
    assign w_adv = (w_mode == MODE_RR) && in_last[w_gnt_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_out_last <= 1'b0;
        end else if (w_xfer) begin
            r_lock     <= ~in_last[w_gnt_idx];
            r_lock_idx <= w_gnt_idx;
            r_out_last <= in_last[w_gnt_idx];
        end
    end

    assign out_last = r_out_last;
`else
    logic w_unused_last;
    assign w_unused_last = ^in_last;
    assign w_adv         = (w_mode == MODE_RR);
    assign out_last      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else if (w_load) begin
            if (w_gnt_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= in_data[w_gnt_idx*W +: W];
                r_out_sel   <= w_gnt_idx;
                if (w_adv) begin
                    r_ptr <= SW'(next_idx(32'(w_gnt_idx), N));
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule
`default_nettype wire
